// File: rtl/lfsr_rng.sv
// -----------------------------------------------------------------------------
// lfsr_rng -- Fibonacci-style LFSR random source with a scaled-output unit.
//
// The LFSR shifts left every clock, inserting the XOR of the TAPS-selected
// state bits at bit 0. A small FSM (IDLE -> REDUCE -> DONE) turns one LFSR
// sample into (raw mod mod_val) + offset by repeated subtraction, then holds
// the result until the consumer acknowledges it.
//
// Parameters:
//   WIDTH     - LFSR / data width in bits (3..16)
//   TAPS      - feedback tap mask (WIDTH bits)
//   SEED_INIT - LFSR value applied at reset
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   seed_load  in   load seed into the LFSR (wins over stepping)
//   seed       in   [WIDTH] seed value
//   mod_val    in   [WIDTH] modulus for the scaled output (0 = bypass)
//   offset     in   [WIDTH] added after reduction, wraps mod 2^WIDTH
//   req        in   request one scaled number (sampled in IDLE only)
//   ack        in   consumer accepts rnd_out (acted on in DONE only)
//   rnd_raw    out  [WIDTH] current LFSR state
//   rnd_out    out  [WIDTH] scaled result, keeps last value after ack
//   valid      out  rnd_out holds a result not yet acknowledged
//   busy       out  high while reducing
//   state_dbg  out  [2] FSM state for debug/checkers (0 IDLE, 1 REDUCE, 2 DONE)
//
// Handshake: a request is taken when req=1 in IDLE. valid rises with the
// result and stays high, with rnd_out stable, until the first cycle with
// ack=1; that edge drops valid and returns to IDLE. req outside IDLE is
// ignored, so a req coinciding with ack does not start a new request.
//
// Build option: define LFSR_LOCKUP_GUARD_EN to force an all-zero LFSR state
// to 1 on the next edge. Without it an all-zero state persists until
// seed_load or rst.
// -----------------------------------------------------------------------------
module lfsr_rng #(
  parameter int             WIDTH     = 7,
  parameter logic [WIDTH-1:0] TAPS      = 7'h60,
  parameter logic [WIDTH-1:0] SEED_INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [WIDTH-1:0] offset,
  input  logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] rnd_raw,
  output logic [WIDTH-1:0] rnd_out,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] off_q;
  logic [WIDTH-1:0] rnd_out_q;
  logic             valid_q;
  logic             feedback;
  logic             reduce_last;

  assign feedback = ^(lfsr_q & TAPS);

  // A zero modulus must still finish in one cycle; without the explicit
  // test the work >= 0 comparison would subtract forever.
  assign reduce_last = (mod_q == '0) || (work_q < mod_q);

  // ---------------------------------------------------------------------------
  // LFSR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_INIT;
    end else if (seed_load) begin
      lfsr_q <= seed;
`ifdef LFSR_LOCKUP_GUARD_EN
    end else if (lfsr_q == '0) begin
      // All-zero is a fixed point of the XOR feedback; kick it back to 1.
      lfsr_q <= {{(WIDTH-1){1'b0}}, 1'b1};
`endif
    end else begin
      lfsr_q <= {lfsr_q[WIDTH-2:0], feedback};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req)         state_d = S_REDUCE;
      S_REDUCE: if (reduce_last) state_d = S_DONE;
      S_DONE:   if (ack)         state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. mod_q/off_q are captured with the sample so that later changes
  // on mod_val/offset (or a seed_load) cannot disturb a result in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q    <= '0;
      mod_q     <= '0;
      off_q     <= '0;
      rnd_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            work_q <= lfsr_q;
            mod_q  <= mod_val;
            off_q  <= offset;
          end
        end
        S_REDUCE: begin
          if (reduce_last) begin
            rnd_out_q <= work_q + off_q;
            valid_q   <= 1'b1;
          end else begin
            work_q <= work_q - mod_q;
          end
        end
        S_DONE: begin
          if (ack) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rnd_raw   = lfsr_q;
  assign rnd_out   = rnd_out_q;
  assign valid     = valid_q;
  assign busy      = (state_q == S_REDUCE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rng -- self-checking bench for lfsr_rng (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
// Compile with LFSR_LOCKUP_GUARD_EN defined to check the lock-up guard build.
// -----------------------------------------------------------------------------
module tb_lfsr_rng;

  localparam int             W         = 7;
  localparam logic [W-1:0]   TAPS      = 7'h60;
  localparam logic [W-1:0]   SEED_INIT = 7'h01;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         seed_load;
  logic [W-1:0] seed;
  logic [W-1:0] mod_val;
  logic [W-1:0] offset;
  logic         req;
  logic         ack;
  logic [W-1:0] rnd_raw;
  logic [W-1:0] rnd_out;
  logic         valid;
  logic         busy;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  lfsr_rng #(
    .WIDTH    (W),
    .TAPS     (TAPS),
    .SEED_INIT(SEED_INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed     (seed),
    .mod_val  (mod_val),
    .offset   (offset),
    .req      (req),
    .ack      (ack),
    .rnd_raw  (rnd_raw),
    .rnd_out  (rnd_out),
    .valid    (valid),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: arithmetic form of the rules
  //   step:   next = (2*s mod 2^W) + parity(s & TAPS)
  //   result: (raw mod m) + off, wrapped to W bits; m = 0 passes raw through
  //   timing: valid on edge floor(raw/m)+2 counting the req edge as edge 1
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
    int v;
    v = (int'(s) * 2) % (1 << W) + ($countones(s & TAPS) % 2);
    return W'(v);
  endfunction

  function automatic logic [W-1:0] model_result(input int raw, input int m, input int off);
    int r;
    r = (m == 0) ? raw : (raw % m);
    return W'((r + off) % (1 << W));
  endfunction

  function automatic int model_latency(input int raw, input int m);
    return (m == 0) ? 2 : (raw / m) + 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic scramble();
    seed_load = 1'($urandom_range(0, 1));
    seed      = W'($urandom);
    mod_val   = W'($urandom);
    offset    = W'($urandom);
    req       = 1'($urandom_range(0, 1));
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    @(negedge clk);
    seed      = s;
    seed_load = 1'b1;
    req       = 1'b0;
    ack       = 1'b0;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // One full transaction: seed the LFSR with raw, request, disturb the inputs
  // while it reduces, hold in DONE for 'hold' cycles, then acknowledge.
  task automatic run_txn(input string tag, input logic [W-1:0] raw, input logic [W-1:0] m,
                         input logic [W-1:0] o, input logic [W-1:0] exp_out,
                         input int exp_lat, input int hold);
    int           edges;
    int           busy_cnt;
    logic [W-1:0] exp_v;
    exp_q.push_back(exp_out);
    load_seed(raw);
    mod_val = m;
    offset  = o;
    req     = 1'b1;
    @(negedge clk);          // req-sampling edge has passed: edge 1
    edges    = 1;
    busy_cnt = 0;
    while (!valid && edges < 400) begin
      if (busy) busy_cnt++;
      scramble();
      @(negedge clk);
      edges++;
    end
    exp_v = exp_q.pop_front();
    chk({tag, " valid_seen"}, 32'(valid), 32'd1);
    chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, " rnd_out"}, 32'(rnd_out), 32'(exp_v));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      scramble();
      req = 1'b1;
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(valid), 32'd1);
      chk({tag, " hold_rnd_out"}, 32'(rnd_out), 32'(exp_v));
      chk({tag, " hold_busy"}, 32'(busy), 32'd0);
    end
    seed_load = 1'b0;
    req       = 1'($urandom_range(0, 1));
    ack       = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    req = 1'b0;
    chk({tag, " ack_valid"}, 32'(valid), 32'd0);
    chk({tag, " ack_rnd_out_kept"}, 32'(rnd_out), 32'(exp_v));
    chk({tag, " ack_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_valid"}, 32'(valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] m;
    logic [W-1:0] off;
    logic [W-1:0] out;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [W-1:0] mdl;
    logic         seen [0:(1<<W)-1];
    logic         zero_seen;
    logic         early_repeat;
    logic         bad;
    int           r_raw, r_m, r_off;

    vecs[0] = '{raw: 7'h41, m: 7'd11,  off: 7'd10,  out: 7'h14, lat: 7};
    vecs[1] = '{raw: 7'h20, m: 7'd0,   off: 7'd3,   out: 7'h23, lat: 2};
    vecs[2] = '{raw: 7'h05, m: 7'd7,   off: 7'd0,   out: 7'h05, lat: 2};
    vecs[3] = '{raw: 7'h0E, m: 7'd7,   off: 7'd1,   out: 7'h01, lat: 4};
    vecs[4] = '{raw: 7'h7F, m: 7'd1,   off: 7'd0,   out: 7'h00, lat: 129};
    vecs[5] = '{raw: 7'h7F, m: 7'h7F,  off: 7'h7F,  out: 7'h7F, lat: 3};
    vecs[6] = '{raw: 7'h64, m: 7'd9,   off: 7'h7F,  out: 7'h00, lat: 13};
    vecs[7] = '{raw: 7'h01, m: 7'h7F,  off: 7'h10,  out: 7'h11, lat: 2};
    vecs[8] = '{raw: 7'h7F, m: 7'd0,   off: 7'h01,  out: 7'h00, lat: 2};

    // Reset state, observed before any clock edge
    rst       = 1'b1;
    seed_load = 1'b0;
    seed      = '0;
    mod_val   = '0;
    offset    = '0;
    req       = 1'b0;
    ack       = 1'b0;
    #1;
    chk("reset rnd_raw", 32'(rnd_raw), 32'(SEED_INIT));
    chk("reset rnd_out", 32'(rnd_out), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Known LFSR sequence from 0x01
    load_seed(7'h01);
    chk("seq start", 32'(rnd_raw), 32'h01);
    begin
      logic [W-1:0] seq [7];
      seq = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        chk($sformatf("seq step%0d", i + 1), 32'(rnd_raw), 32'(seq[i]));
      end
    end

    // Full period from 0x01 against the model
    load_seed(7'h01);
    mdl          = 7'h01;
    zero_seen    = 1'b0;
    early_repeat = 1'b0;
    for (int i = 0; i < (1 << W); i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 127; i++) begin
      @(negedge clk);
      mdl = model_step(mdl);
      chk($sformatf("period step%0d", i), 32'(rnd_raw), 32'(mdl));
      if (rnd_raw == '0) zero_seen = 1'b1;
      if (i < 127 && seen[rnd_raw]) early_repeat = 1'b1;
      seen[rnd_raw] = 1'b1;
    end
    chk("period returns to 0x01", 32'(rnd_raw), 32'h01);
    chk("period no zero", 32'(zero_seen), 32'd0);
    chk("period no early repeat", 32'(early_repeat), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].raw, vecs[i].m, vecs[i].off,
              vecs[i].out, vecs[i].lat, i % 4);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      r_raw = $urandom_range(0, 127);
      r_m   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
      r_off = $urandom_range(0, 127);
      run_txn($sformatf("rnd%0d", i), W'(r_raw), W'(r_m), W'(r_off),
              model_result(r_raw, r_m, r_off), model_latency(r_raw, r_m),
              $urandom_range(0, 3));
    end

    // All-zero seed
    load_seed(7'h00);
    chk("zero seed loaded", 32'(rnd_raw), 32'h00);
`ifdef LFSR_LOCKUP_GUARD_EN
    @(negedge clk);
    chk("zero seed guarded", 32'(rnd_raw), 32'h01);
    @(negedge clk);
    chk("zero seed resumes", 32'(rnd_raw), 32'(model_step(7'h01)));
`else
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_raw != '0) bad = 1'b1;
    end
    chk("zero seed persists", 32'(bad), 32'd0);
`endif

    // Asynchronous reset in the middle of a long reduction
    load_seed(7'h7F);
    mod_val = 7'd1;
    offset  = 7'd0;
    req     = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreduce busy before rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midreduce rst valid", 32'(valid), 32'd0);
    chk("midreduce rst busy", 32'(busy), 32'd0);
    chk("midreduce rst rnd_out", 32'(rnd_out), 32'd0);
    chk("midreduce rst rnd_raw", 32'(rnd_raw), 32'(SEED_INIT));
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (valid || busy) bad = 1'b1;
    end
    chk("midreduce no valid after rst", 32'(bad), 32'd0);

    // Asynchronous reset while holding a result in DONE
    load_seed(7'h05);
    mod_val = 7'd7;
    offset  = 7'd9;
    req     = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("middone valid before rst", 32'(valid), 32'd1);
    chk("middone rnd_out before rst", 32'(rnd_out), 32'(model_result(5, 7, 9)));
    #2 rst = 1'b1;
    #1;
    chk("middone rst valid", 32'(valid), 32'd0);
    chk("middone rst rnd_out", 32'(rnd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid || busy) bad = 1'b1;
    end
    chk("middone stays idle", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 SHALL have parameter WIDTH, default 7, LFSR and data width in bits (3..16).
REQ-002 SHALL have parameter TAPS, default 7'h60, feedback mask of WIDTH bits; the feedback bit is the XOR of state bits selected by TAPS.
REQ-003 SHALL have parameter SEED_INIT, default 1, LFSR value applied at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port seed_load, input, 1 bit: load seed into the LFSR.
REQ-007 SHALL have port seed, input, WIDTH bits: seed value.
REQ-008 SHALL have port mod_val, input, WIDTH bits: runtime modulus for the scaled output.
REQ-009 SHALL have port offset, input, WIDTH bits: added after reduction.
REQ-010 SHALL have port req, input, 1 bit: request one scaled number.
REQ-011 SHALL have port ack, input, 1 bit: consumer accepts rnd_out.
REQ-012 SHALL have port rnd_raw, output, WIDTH bits: current LFSR state.
REQ-013 SHALL have port rnd_out, output, WIDTH bits: scaled result.
REQ-014 SHALL have port valid, output, 1 bit: rnd_out holds a result.
REQ-015 SHALL have port busy, output, 1 bit: high in REDUCE.

Function
REQ-016 LFSR SHALL step every cycle: next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-017 seed_load SHALL take priority over stepping; the LFSR equals seed on the following cycle.
REQ-018 FSM states SHALL be IDLE, REDUCE and DONE.
REQ-019 IDLE: on req=1, work <= rnd_raw, mod_q <= mod_val, off_q <= offset; go to REDUCE.
REQ-020 REDUCE, per cycle: if work >= mod_q then work <= work - mod_q; otherwise rnd_out <= work + off_q (mod 2^WIDTH), valid <= 1, go to DONE.
REQ-021 If mod_q = 0, REDUCE SHALL exit on its first cycle with rnd_out = raw + off_q (bypass, no hang).
REQ-022 Latency from the req-sampling edge to valid high SHALL be k+2 edges, where k = floor(raw/mod_q).
REQ-023 DONE: valid and rnd_out SHALL hold stable until ack=1; on ack, valid <= 0 and go to IDLE.
REQ-024 req in REDUCE or DONE SHALL be ignored; req and ack in the same cycle in DONE SHALL return to IDLE only.
REQ-025 seed_load or changes to mod_val/offset during REDUCE/DONE SHALL NOT affect the result in progress.
REQ-026 rnd_out SHALL keep its last value after ack.

Reset
REQ-027 rst=1 SHALL immediately set LFSR=SEED_INIT, state=IDLE, work=0, rnd_out=0, valid=0, busy=0, independent of clk.
REQ-028 Reset mid-REDUCE or mid-DONE SHALL abort the request; no valid pulse follows.

Configuration
REQ-029 Macro LFSR_LOCKUP_GUARD_EN defined: an all-zero LFSR state (from seed or SEED_INIT) SHALL be replaced by 1 on the next edge, and stepping resumes from there.
REQ-030 Macro LFSR_LOCKUP_GUARD_EN undefined: an all-zero state SHALL persist until seed_load or rst.

Verification
REQ-031 Reset, then seed_load with seed=0x01, then 7 free-running steps -> rnd_raw sequence 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, 0x03.
REQ-032 Free-run from 0x01 for 127 cycles -> state returns to 0x01; no repeat earlier; 0x00 never appears.
REQ-033 raw=0x41, mod_val=11, offset=10, req pulse -> busy for 6 cycles, valid on the 7th edge, rnd_out=0x14; held until ack.
REQ-034 mod_val=0, raw=0x20, offset=3 -> valid 2 edges after req, rnd_out=0x23.
REQ-035 seed=0 loaded -> with macro: rnd_raw=0x01 the next cycle; without macro: rnd_raw stays 0x00 for 20 cycles.
REQ-036 rst asserted asynchronously mid-REDUCE -> valid=0, busy=0, rnd_out=0, rnd_raw=SEED_INIT before the next edge.
